// File: rtl/i2c_scl_gen_if.sv
// Bus between the I2C bit/byte FSM and the SCL/phase-tick generator.
// The master side drives the enable, divisor and stretch inputs; the generator returns the SCL level and the strobes.
interface i2c_scl_gen_if #(
    parameter int DIV_WIDTH = 16,
    parameter int PHASES    = 4
);
    localparam int PHASE_W = (PHASES > 1) ? $clog2(PHASES) : 1;

    logic                 en_i;
    logic [DIV_WIDTH-1:0] div_i;
    logic                 div_load_i;
    logic                 stretch_i;
    logic                 scl_o;
    logic                 tick_o;
    logic [PHASE_W-1:0]   phase_o;
    logic                 period_o;
    logic                 stretched_o;

    modport master (
        output en_i, div_i, div_load_i, stretch_i,
        input  scl_o, tick_o, phase_o, period_o, stretched_o
    );

    modport slave (
        input  en_i, div_i, div_load_i, stretch_i,
        output scl_o, tick_o, phase_o, period_o, stretched_o
    );
endinterface

// File: rtl/i2c_scl_gen.sv
// Runtime-programmable SCL level and phase-tick generator; all strobes are clock enables on clk_i.
// A new divisor only takes effect at the start of phase 0, so no phase is ever truncated.
module i2c_scl_gen #(
    parameter int CLK_IN    = 100_000_000,
    parameter int CLK_OUT   = 400_000,
    parameter int PHASES    = 4,
    parameter int DIV_WIDTH = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    i2c_scl_gen_if.slave bus
);

    localparam int PHASE_W = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int DEFAULT_DIV_INT = CLK_IN / (CLK_OUT * PHASES) - 1;

    localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV = DIV_WIDTH'(DEFAULT_DIV_INT);
    localparam logic [DIV_WIDTH-1:0] ZERO_CNT    = {DIV_WIDTH{1'b0}};
    localparam logic [DIV_WIDTH-1:0] ONE_CNT     = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PHASE_W-1:0]   ZERO_PH     = {PHASE_W{1'b0}};
    localparam logic [PHASE_W-1:0]   ONE_PH      = {{(PHASE_W-1){1'b0}}, 1'b1};
    localparam logic [PHASE_W-1:0]   LAST_PH     = PHASE_W'(PHASES - 1);
    localparam logic [PHASE_W-1:0]   HALF_PH     = PHASE_W'(PHASES / 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_vld_q, pend_vld_d;
    logic                 scl_q, scl_d;
    logic                 tick_q, tick_d;
    logic                 period_q, period_d;
    logic                 stretched_q, stretched_d;
    logic                 wrap_zero_s;

    // A zero divisor would give a one-cycle phase; the minimum phase is two cycles.
    function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
        logic [DIV_WIDTH-1:0] r;
        if (v == ZERO_CNT) begin
            r = ONE_CNT;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Phase sequencing: enable start, stretch hold, phase wrap and the SCL level of the next phase.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        scl_d       = scl_q;
        tick_d      = 1'b0;
        period_d    = 1'b0;
        wrap_zero_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d   = ZERO_CNT;
                phase_d = ZERO_PH;
                if (bus.en_i) begin
                    state_d  = ST_RUN;
                    scl_d    = 1'b0;
                    tick_d   = 1'b1;
                    period_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    scl_d   = 1'b1;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (!bus.en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO_CNT;
                    phase_d = ZERO_PH;
                    scl_d   = 1'b1;
                end else if (scl_q && bus.stretch_i) begin
                    // Slave is holding the released line low: freeze where we are.
                    state_d = ST_HOLD;
                end else if (cnt_q >= div_q) begin
                    state_d     = ST_RUN;
                    cnt_d       = ZERO_CNT;
                    phase_d     = (phase_q == LAST_PH) ? ZERO_PH : phase_q + ONE_PH;
                    tick_d      = 1'b1;
                    scl_d       = (phase_d >= HALF_PH);
                    period_d    = (phase_d == ZERO_PH);
                    wrap_zero_s = (phase_d == ZERO_PH);
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_q + ONE_CNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = ZERO_CNT;
                phase_d = ZERO_PH;
                scl_d   = 1'b1;
            end
        endcase
        stretched_d = (state_d == ST_HOLD);
    end

    // Divisor shadow: idle loads land immediately, running loads wait for the next period start.
    always_comb begin
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (wrap_zero_s) begin
            if (bus.div_load_i) begin
                div_d = clamp_div(bus.div_i);
            end else if (pend_vld_q) begin
                div_d = pend_q;
            end else begin
                div_d = div_q;
            end
            pend_vld_d = 1'b0;
        end else if (bus.div_load_i) begin
            if (!bus.en_i) begin
                div_d      = clamp_div(bus.div_i);
                pend_vld_d = 1'b0;
            end else begin
                pend_d     = clamp_div(bus.div_i);
                pend_vld_d = 1'b1;
            end
        end else begin
            pend_vld_d = pend_vld_q;
        end
    end

    // State, divisor and output registers; reset dominates every other input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= ZERO_CNT;
            phase_q     <= ZERO_PH;
            div_q       <= DEFAULT_DIV;
            pend_q      <= ZERO_CNT;
            pend_vld_q  <= 1'b0;
            scl_q       <= 1'b1;
            tick_q      <= 1'b0;
            period_q    <= 1'b0;
            stretched_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            scl_q       <= scl_d;
            tick_q      <= tick_d;
            period_q    <= period_d;
            stretched_q <= stretched_d;
        end
    end

    assign bus.scl_o       = scl_q;
    assign bus.tick_o      = tick_q;
    assign bus.phase_o     = phase_q;
    assign bus.period_o    = period_q;
    assign bus.stretched_o = stretched_q;

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

Parametrised, runtime-programmable SCL/phase-tick generator for the I2C master. It is the successor to the fixed-ratio clock divider. It produces a registered SCL level plus one-cycle phase-tick strobes on the system clock, which the byte/bit FSM uses as clock enables; no derived clock is ever generated. It adds a runtime divisor with glitch-free period-boundary update, N-phase subdivision of each SCL period, and slave clock-stretching support.

## Interface
- CLK_IN, 100_000_000, system clock frequency in Hz
- CLK_OUT, 400_000, reset-default SCL frequency in Hz
- PHASES, 4, phases per SCL period; even, >= 2
- DIV_WIDTH, 16, width of the divisor register
- DEFAULT_DIV (localparam), CLK_IN/(CLK_OUT*PHASES) - 1; must fit in DIV_WIDTH and be >= 1
- clk_i  in  1  system clock; the only clock
- rst_i  in  1  synchronous reset, active-high
- en_i  in  1  run enable; low = idle
- div_i  in  DIV_WIDTH  requested phase divisor (phase length = value+1 cycles)
- div_load_i  in  1  one-cycle strobe that captures div_i
- stretch_i  in  1  synchronised SCL line state is low (slave holding SCL)
- scl_o  out  1  SCL level to pad driver (1 = release)
- tick_o  out  1  one-cycle strobe marking the first cycle of every phase
- phase_o  out  $clog2(PHASES)  current phase index
- period_o  out  1  one-cycle strobe marking the first cycle of phase 0
- stretched_o  out  1  high while the count is frozen by stretching

## Operation
- State: cnt (DIV_WIDTH), phase (0..PHASES-1), div_q (active divisor), div_pend + pend_vld (shadow).
- Reset: cnt=0, phase=0, div_q=DEFAULT_DIV, pend_vld=0, scl_o=1, tick_o=0, period_o=0, phase_o=0, stretched_o=0.
- Idle (en_i=0): cnt=0, phase=0, scl_o=1, no strobes. A load is applied to div_q immediately.
- Run (en_i=1): cnt increments each cycle. Wrap occurs when cnt==div_q and there is no hold: cnt<=0 and phase<=(phase+1) mod PHASES.
- SCL level (registered from the next phase): 0 for phase < PHASES/2, 1 otherwise. Disabled = 1.
- Hold: when scl_o==1 and stretch_i==1, cnt and phase freeze, no tick is issued, and stretched_o=1. The count resumes on the cycle after stretch_i falls.
- Divisor clamp: div_i==0 is stored as 1 (minimum 2 cycles per phase).
- Load while running: div_i is stored in div_pend and pend_vld=1. It transfers to div_q only on a wrap into phase 0. A newer load overwrites a pending one.
- Load on the same cycle as a wrap into phase 0: div_i is applied directly at that wrap.

## Timing
- Phase length = div_q+1 cycles. Period = PHASES*(div_q+1) cycles plus stretch cycles.
- Defaults: DEFAULT_DIV=61 → 62-cycle phase, 248-cycle period.
- All outputs are registered; there is no combinational path from input to output.
- tick_o, phase_o and scl_o update on the same edge (the wrap edge). tick_o is high for the one following cycle. period_o = tick_o && phase_o==0.
- Enable rising edge: next cycle phase_o=0, scl_o=0, tick_o=1, period_o=1. The first wrap follows div_q+1 cycles later.
- Enable falling mid-period: next cycle idle state, scl_o=1, no tick; an in-progress phase is abandoned.
- stretched_o asserts the cycle after stretch_i is sampled high with scl_o=1. It deasserts the cycle after stretch_i is sampled low.
- rst_i has priority over en_i, loads and stretch. A reset mid-operation returns to the reset state on the next edge and also restores div_q to DEFAULT_DIV.

## Test plan
- Default rate: reset, en_i=1 → tick_o every 62 cycles, period_o every 248 cycles, scl_o low 124 / high 124 cycles, phase_o sequence 0,1,2,3.
- Runtime load: load div_i=9 during phase 1 → remainder of the current period unchanged at 62/phase; from the next phase 0, ticks every 10 cycles; no truncated phase.
- Stretch: hold stretch_i=1 for 50 cycles starting 3 cycles into phase 2 → stretched_o high 50 cycles, phase 2 lasts 62+50 cycles, no tick during the hold.
- Clamp and coincidence: load div_i=0 on the exact wrap into phase 0 → applied at that wrap, phase length 2 cycles.
- Disable and reset mid-op: drop en_i in phase 3 → scl_o=1 next cycle, no strobes. Re-enable → tick_o+period_o next cycle. Assert rst_i after a load of 9 → div_q back to 61, all outputs at reset values.
